// File: rtl/irf_bypass_ctrl_if.sv
// Decode-to-bypass-controller bus: operand/destination info in, bypass selects,
// load-use stall and IRF write port out.
interface irf_bypass_ctrl_if #(
  parameter int unsigned AW = 5
);
  logic          dec_valid;
  logic [AW-1:0] dec_ra;
  logic [AW-1:0] dec_rb;
  logic          dec_rb_used;
  logic          dec_wr;
  logic [AW-1:0] dec_dest;
  logic          dec_is_load;
  logic          hold;
  logic [2:0]    mux3_sel;
  logic [2:0]    mux4_sel;
  logic          stall;
  logic          write_en;
  logic [AW-1:0] write_addr;

  modport master (
    output dec_valid, dec_ra, dec_rb, dec_rb_used, dec_wr, dec_dest, dec_is_load, hold,
    input  mux3_sel, mux4_sel, stall, write_en, write_addr
  );

  modport slave (
    input  dec_valid, dec_ra, dec_rb, dec_rb_used, dec_wr, dec_dest, dec_is_load, hold,
    output mux3_sel, mux4_sel, stall, write_en, write_addr
  );
endinterface

// File: rtl/irf_bypass_ctrl.sv
// Integer register file hazard/forwarding controller: tracks producers in E3/E4/WB,
// drives operand bypass selects, the load-use stall and the IRF write port.
module irf_bypass_ctrl #(
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input logic              clk,
  input logic              reset,
  irf_bypass_ctrl_if.slave bus
);

  localparam logic [AW-1:0] ZeroReg = AW'(ZERO_REG);

  localparam logic [2:0] SelIrf  = 3'd0;
  localparam logic [2:0] SelRes3 = 3'd1;
  localparam logic [2:0] SelRes4 = 3'd2;
  localparam logic [2:0] SelMem  = 3'd3;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] dest;
    logic          ld;
  } slot_t;

  slot_t         e3_q, e4_q, e3_d;
  logic          wb_v_q;
  logic [AW-1:0] wb_dest_q;

  logic a_e3, a_e4, b_e3, b_e4;
  logic stall_a, stall_b, stall;

  function automatic logic match(input slot_t s, input logic [AW-1:0] r);
    return s.v && (s.dest == r) && (r != ZeroReg);
  endfunction

  // Youngest producer wins; a load still in E3 cannot be forwarded (stall case).
  function automatic logic [2:0] pick(input logic m3, input logic ld3,
                                      input logic m4, input logic ld4);
    if (m3)      return ld3 ? SelIrf : SelRes3;
    else if (m4) return ld4 ? SelMem : SelRes4;
    else         return SelIrf;
  endfunction

  always_comb begin
    a_e3    = match(e3_q, bus.dec_ra);
    a_e4    = match(e4_q, bus.dec_ra);
    b_e3    = match(e3_q, bus.dec_rb);
    b_e4    = match(e4_q, bus.dec_rb);
    stall_a = a_e3 & e3_q.ld;
    stall_b = bus.dec_rb_used & b_e3 & e3_q.ld;
    stall   = bus.dec_valid & (stall_a | stall_b);

    bus.mux3_sel = SelIrf;
    bus.mux4_sel = SelIrf;
    if (bus.dec_valid) begin
      bus.mux3_sel = pick(a_e3, e3_q.ld, a_e4, e4_q.ld);
      if (bus.dec_rb_used) bus.mux4_sel = pick(b_e3, e3_q.ld, b_e4, e4_q.ld);
    end
    bus.stall = stall;

    // A stalled instruction is replaced by a bubble entering E3.
    e3_d.v    = bus.dec_valid & bus.dec_wr & ~stall & (bus.dec_dest != ZeroReg);
    e3_d.dest = bus.dec_dest;
    e3_d.ld   = bus.dec_is_load;

    bus.write_en   = wb_v_q & ~bus.hold;
    bus.write_addr = wb_v_q ? wb_dest_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e3_q      <= '0;
      e4_q      <= '0;
      wb_v_q    <= 1'b0;
      wb_dest_q <= '0;
    end else if (!bus.hold) begin
      wb_v_q    <= e4_q.v;
      wb_dest_q <= e4_q.dest;
      e4_q      <= e3_q;
      e3_q      <= e3_d;
    end
  end

endmodule

// File: tb/tb_irf_bypass_ctrl.sv
// Scoreboard bench for irf_bypass_ctrl: directed hazard scenarios followed by random
// traffic, checked against an issue-history model of the pipeline.
module tb_irf_bypass_ctrl;

  localparam int unsigned AW   = 5;
  localparam logic [4:0]  ZREG = 5'd31;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irf_bypass_ctrl_if #(.AW(AW)) bus ();

  irf_bypass_ctrl #(.AW(AW), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // One record per pipeline advance; index 0 is the youngest (E3), 2 is WB.
  typedef struct {
    bit         v;
    logic [4:0] dest;
    bit         ld;
  } rec_t;

  typedef struct {
    logic [2:0] s3;
    logic [2:0] s4;
    bit         stall;
    bit         we;
    logic [4:0] wa;
  } exp_t;

  rec_t hist[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void clear_hist();
    rec_t blank;
    blank.v = 0; blank.dest = '0; blank.ld = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(blank);
  endfunction

  // Source for register r: forward from the youngest in-flight producer by its age.
  function automatic logic [3:0] source_of(input logic [4:0] r);
    if (r == ZREG) return 4'd0;
    for (int age = 0; age < 3; age++) begin
      if (hist[age].v && hist[age].dest == r) begin
        case (age)
          0:       return hist[age].ld ? 4'b1_000 : 4'b0_001;
          1:       return hist[age].ld ? 4'd3 : 4'd2;
          default: return 4'd0;
        endcase
      end
    end
    return 4'd0;
  endfunction

  task automatic issue(input bit v, input logic [4:0] ra, input logic [4:0] rb,
                       input bit rbu, input bit wr, input logic [4:0] dest,
                       input bit ld, input bit hld, input bit rst);
    exp_t e;
    logic [3:0] sa, sbv;
    rec_t nr;
    bus.dec_valid = v;  bus.dec_ra = ra;  bus.dec_rb = rb;  bus.dec_rb_used = rbu;
    bus.dec_wr = wr;    bus.dec_dest = dest; bus.dec_is_load = ld; bus.hold = hld;
    reset = rst;
    if (rst) clear_hist();
    sa  = source_of(ra);
    sbv = source_of(rb);
    e.stall = v && (sa[3] || (rbu && sbv[3]));
    e.s3    = v ? sa[2:0] : 3'd0;
    e.s4    = (v && rbu) ? sbv[2:0] : 3'd0;
    e.we    = hist[2].v && !hld;
    e.wa    = hist[2].v ? hist[2].dest : 5'd0;
    sb.push_back(e);
    @(posedge clk);
    if (rst) clear_hist();
    else if (!hld) begin
      nr.v = v && wr && !e.stall && dest != ZREG;
      nr.dest = dest; nr.ld = ld;
      hist.push_front(nr);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic nop(input bit hld = 0);
    issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, hld, 0);
  endtask

  // Producer: writes dest, optionally a load.
  task automatic prod(input logic [4:0] dest, input bit ld);
    issue(1, 5'd30, 5'd30, 0, 1, dest, ld, 0, 0);
  endtask

  task automatic cons(input logic [4:0] ra, input logic [4:0] rb, input bit rbu);
    issue(1, ra, rb, rbu, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("mux3_sel",   int'(bus.mux3_sel),   int'(e.s3));
      cmp("mux4_sel",   int'(bus.mux4_sel),   int'(e.s4));
      cmp("stall",      int'(bus.stall),      int'(e.stall));
      cmp("write_en",   int'(bus.write_en),   int'(e.we));
      cmp("write_addr", int'(bus.write_addr), int'(e.wa));
    end
  end

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 5))
      0:       return 5'd1;
      1:       return 5'd2;
      2:       return 5'd3;
      3:       return ZREG;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    clear_hist();
    reset = 1'b1;
    bus.dec_valid = 0; bus.dec_ra = '0; bus.dec_rb = '0; bus.dec_rb_used = 0;
    bus.dec_wr = 0; bus.dec_dest = '0; bus.dec_is_load = 0; bus.hold = 0;
    @(posedge clk);
    #1;
    issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    issue(1, 5'd1, 5'd1, 1, 1, 5'd1, 0, 0, 1);

    // ALU producer forwarded at distances 1, 2 and 3.
    prod(5'd1, 0); cons(5'd1, 5'd0, 0);
    prod(5'd1, 0); nop(); cons(5'd1, 5'd0, 0);
    prod(5'd1, 0); nop(); nop(); cons(5'd1, 5'd0, 0);
    nop(); nop(); nop();
    // Load-use on B: stall then memory forward.
    prod(5'd2, 1); cons(5'd0, 5'd2, 1); cons(5'd0, 5'd2, 1);
    nop(); nop(); nop();
    // Zero register never tracked.
    prod(ZREG, 0); cons(ZREG, ZREG, 1); prod(ZREG, 1); cons(ZREG, ZREG, 1);
    nop(); nop(); nop();
    // Back-to-back writers of r3: youngest wins.
    prod(5'd3, 0); prod(5'd3, 1); cons(5'd3, 5'd3, 1); cons(5'd3, 5'd3, 1);
    nop(); nop(); nop();
    prod(5'd3, 0); prod(5'd3, 0); cons(5'd3, 5'd3, 1); nop(); nop(); nop();
    // Hold freezes the slots with a producer in E3.
    prod(5'd1, 0);
    for (int i = 0; i < 3; i++) issue(1, 5'd1, 5'd1, 1, 0, 5'd0, 0, 1, 0);
    cons(5'd1, 5'd0, 0); nop(); nop(); nop();
    // Reset with three producers in flight.
    prod(5'd1, 0); prod(5'd2, 0); prod(5'd3, 1);
    issue(1, 5'd3, 5'd1, 1, 0, 5'd0, 0, 0, 1);
    cons(5'd1, 5'd3, 1); nop(); nop(); nop();

    for (int n = 0; n < 3000; n++) begin
      issue($urandom_range(0, 9) != 0, rnd_reg(), rnd_reg(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0, rnd_reg(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
